// File: rtl/noc_input_buffer.sv
// Per-port NoC router input buffer: circular flit FIFO, packet framing FSM,
// arbiter request generation and orphan-flit discard.
module noc_input_buffer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_flit,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    gnt,
  output logic [DATA_WIDTH-1:0]   out_flit,
  output logic                    out_valid,
  output logic [2:0]              flit_id,
  output logic [11:0]             length,
  output logic                    req,
  output logic                    drop,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] T_HEAD = 3'b001;
  localparam logic [2:0] T_TAIL = 3'b100;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, wr_vis_q, rd_ptr_q, rd_ptr_d;
  logic [11:0]           length_q, length_d;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            head_type;

  // The read side sees the write pointer one cycle late, so a freshly written
  // entry reaches the head one cycle after its push edge.
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty     = (wr_vis_q == rd_ptr_q);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_type = head[DATA_WIDTH-1 -: 3];
  assign out_flit  = empty ? '0 : head;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign req       = (state_q == ACTIVE);
  assign length    = length_q;
  assign wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    pop       = 1'b0;
    drop      = 1'b0;
    out_valid = 1'b0;
    flit_id   = 3'b000;
    // Nothing leaves the buffer while reset is flushing it.
    if (!rst) begin
      if (state_q == IDLE) begin
        if (!empty) begin
          if (head_type == T_HEAD) begin
            length_d = head[DATA_WIDTH-4 -: 12];
            state_d  = ACTIVE;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end else begin
        if (!empty) flit_id = head_type;
        if (gnt && !empty) begin
          pop       = 1'b1;
          out_valid = 1'b1;
          if (head_type == T_TAIL) state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      rd_ptr_q <= '0;
      length_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_vis_q <= wr_ptr_q;
      rd_ptr_q <= rd_ptr_d;
      length_q <= length_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= in_flit;
  end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer: reset, single packet, orphans,
// withheld grant, full/backpressure, mid-packet reset, back-to-back with wrap.
module tb_noc_input_buffer;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, gnt, out_valid, req, drop;
  logic [DW-1:0] in_flit, out_flit;
  logic [2:0]    flit_id;
  logic [11:0]   length;
  logic [3:0]    count;
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   pkt_q [12];
  logic [11:0]   lens [3];
  int            k, lows;
  logic          seen;

  always #5 clk = ~clk;

  noc_input_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .gnt(gnt), .out_flit(out_flit), .out_valid(out_valid),
    .flit_id(flit_id), .length(length), .req(req), .drop(drop), .count(count)
  );

  function automatic logic [31:0] hdr(input logic [11:0] len, input logic [16:0] p);
    return {3'b001, len, p};
  endfunction
  function automatic logic [31:0] bdy(input logic [28:0] p);
    return {3'b010, p};
  endfunction
  function automatic logic [31:0] tl(input logic [28:0] p);
    return {3'b100, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic v, input logic [31:0] f, input logic g);
    in_valid = v;
    in_flit  = f;
    gnt      = g;
    #1;
  endtask

  initial begin
    // Reset held two edges with a valid flit presented
    rst = 1'b1;
    drv(1'b1, hdr(12'd9, 17'h1), 1'b0);
    nxt(); nxt();
    rst = 1'b0;
    drv(1'b0, 32'h0, 1'b0);
    chk("rst_count", 32'(count), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_flit_id", 32'(flit_id), 0);
    chk("rst_length", 32'(length), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_flit", out_flit, 0);
    nxt();
    chk("rst_nowrite", 32'(count), 0);
    chk("rst_drop", 32'(drop), 0);

    // Single packet, grant held high
    drv(1'b1, hdr(12'd5, 17'h11), 1'b1);
    chk("p1_req_pre", 32'(req), 0);
    nxt();
    drv(1'b1, bdy(29'h22), 1'b1);
    chk("p1_count1", 32'(count), 1);
    chk("p1_req_n", 32'(req), 0);
    nxt();
    drv(1'b1, tl(29'h33), 1'b1);
    chk("p1_req_n1", 32'(req), 0);
    chk("p1_ov_n1", 32'(out_valid), 0);
    nxt();
    drv(1'b0, 32'h0, 1'b1);
    chk("p1_req_n2", 32'(req), 1);
    chk("p1_length", 32'(length), 5);
    chk("p1_id_hdr", 32'(flit_id), 1);
    chk("p1_ov_hdr", 32'(out_valid), 1);
    chk("p1_flit_hdr", out_flit, hdr(12'd5, 17'h11));
    nxt();
    chk("p1_id_body", 32'(flit_id), 2);
    chk("p1_ov_body", 32'(out_valid), 1);
    chk("p1_flit_body", out_flit, bdy(29'h22));
    nxt();
    chk("p1_id_tail", 32'(flit_id), 4);
    chk("p1_ov_tail", 32'(out_valid), 1);
    chk("p1_flit_tail", out_flit, tl(29'h33));
    nxt();
    chk("p1_req_fall", 32'(req), 0);
    chk("p1_ov_end", 32'(out_valid), 0);
    chk("p1_count_end", 32'(count), 0);
    chk("p1_length_hold", 32'(length), 5);

    // Orphans: body and tail are discarded, then a header is accepted
    drv(1'b1, bdy(29'h44), 1'b0);
    chk("orph_drop0", 32'(drop), 0);
    nxt();
    drv(1'b1, tl(29'h55), 1'b0);
    chk("orph_drop_early", 32'(drop), 0);
    nxt();
    drv(1'b1, hdr(12'd7, 17'h66), 1'b0);
    chk("orph_drop1", 32'(drop), 1);
    nxt();
    drv(1'b0, 32'h0, 1'b0);
    chk("orph_drop2", 32'(drop), 1);
    nxt();
    chk("orph_drop_off", 32'(drop), 0);
    chk("orph_req_lo", 32'(req), 0);
    nxt();
    chk("orph_req", 32'(req), 1);
    chk("orph_id", 32'(flit_id), 1);
    chk("orph_length", 32'(length), 7);
    chk("orph_count", 32'(count), 1);

    // Grant withheld for 20 cycles with a full packet buffered
    drv(1'b1, bdy(29'h77), 1'b0);
    nxt();
    drv(1'b1, tl(29'h88), 1'b0);
    nxt();
    drv(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("hold_req", 32'(req), 1);
      chk("hold_id", 32'(flit_id), 1);
      chk("hold_count", 32'(count), 3);
      chk("hold_flit", out_flit, hdr(12'd7, 17'h66));
      nxt();
    end
    drv(1'b0, 32'h0, 1'b1);
    chk("hold_ov", 32'(out_valid), 1);
    chk("hold_out_hdr", out_flit, hdr(12'd7, 17'h66));
    nxt();
    chk("hold_out_body", out_flit, bdy(29'h77));
    nxt();
    chk("hold_out_tail", out_flit, tl(29'h88));
    chk("hold_ov_tail", 32'(out_valid), 1);
    nxt();
    drv(1'b0, 32'h0, 1'b0);
    chk("hold_req_end", 32'(req), 0);
    chk("hold_count_end", 32'(count), 0);

    // Full and backpressure: 10 offered, 8 accepted
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drv(1'b1, hdr(12'd3, 17'h100), 1'b0);
      else        drv(1'b1, bdy(29'(32'h200 + i)), 1'b0);
      chk("full_in_ready", 32'(in_ready), (i < 8) ? 1 : 0);
      nxt();
      chk("full_count", 32'(count), (i < 7) ? i + 1 : 8);
    end
    chk("full_req", 32'(req), 1);
    drv(1'b1, bdy(29'h3FF), 1'b1);
    chk("full_pop_ov", 32'(out_valid), 1);
    chk("full_pop_ready", 32'(in_ready), 0);
    chk("full_pop_flit", out_flit, hdr(12'd3, 17'h100));
    nxt();
    drv(1'b0, 32'h0, 1'b0);
    chk("full_after_count", 32'(count), 7);
    chk("full_after_ready", 32'(in_ready), 1);
    chk("full_after_head", out_flit, bdy(29'h201));

    // Reset mid-packet flushes without emitting
    rst = 1'b1;
    drv(1'b1, bdy(29'h5), 1'b1);
    chk("mrst_ov", 32'(out_valid), 0);
    nxt();
    rst = 1'b0;
    drv(1'b0, 32'h0, 1'b0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_req", 32'(req), 0);
    chk("mrst_id", 32'(flit_id), 0);
    chk("mrst_length", 32'(length), 0);
    chk("mrst_flit", out_flit, 0);
    chk("mrst_ready", 32'(in_ready), 1);

    // Back-to-back packets streamed with grant high; pointers wrap
    lens[0] = 12'd4; lens[1] = 12'd9; lens[2] = 12'hABC;
    for (int p = 0; p < 3; p++) begin
      pkt_q[p*4]     = hdr(lens[p], 17'(p + 1));
      pkt_q[p*4 + 1] = bdy(29'(16 * p + 1));
      pkt_q[p*4 + 2] = bdy(29'(16 * p + 2));
      pkt_q[p*4 + 3] = tl(29'(16 * p + 3));
    end
    k = 0; lows = 0; seen = 1'b0;
    for (int c = 0; c < 60 && k < 12; c++) begin
      if (c < 12) drv(1'b1, pkt_q[c], 1'b1);
      else        drv(1'b0, 32'h0, 1'b1);
      if (req) seen = 1'b1;
      else if (seen) lows++;
      if (out_valid) begin
        chk("b2b_flit", out_flit, pkt_q[k]);
        if (out_flit[31:29] == 3'b001) chk("b2b_length", 32'(length), 32'(lens[k/4]));
        k++;
      end
      nxt();
    end
    drv(1'b0, 32'h0, 1'b0);
    chk("b2b_all_out", k, 12);
    chk("b2b_req_gaps", lows, 2);
    chk("b2b_req_end", 32'(req), 0);
    chk("b2b_count_end", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_input_buffer.md
# noc_input_buffer

Per-port input buffer for the 5-port NoC router, one instance per direction (L, N, E, W, S). Accepts flits from the upstream link with a valid/ready handshake and stores them in a FIFO. Tracks packet framing and drives the per-port `req`, `flit_id` and `length` signals consumed by the router arbiter. Pops one flit per cycle toward the crossbar while the arbiter grants this port.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DATA_WIDTH`, 32: flit width; ≥15.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_flit`  in  DATA_WIDTH  flit from upstream link.
- `in_valid`  in  1  upstream flit valid.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `gnt`  in  1  arbiter/crossbar grant; pops head flit when `req` is high.
- `out_flit`  out  DATA_WIDTH  head flit; 0 when empty.
- `out_valid`  out  1  head flit popped this cycle (`gnt && req && !empty`).
- `flit_id`  out  3  head flit type to arbiter; 3'b000 unless ACTIVE and non-empty.
- `length`  out  12  packet length latched from the current header.
- `req`  out  1  request to arbiter; high in ACTIVE.
- `drop`  out  1  one-cycle pulse per discarded orphan flit.
- `count`  out  log2(DEPTH)+1  current occupancy.

## Operation
- Flit format: `in_flit[DATA_WIDTH-1:DATA_WIDTH-3]` = type: 3'b001 header, 3'b010 body, 3'b100 tail. On a header, `in_flit[DATA_WIDTH-4:DATA_WIDTH-15]` = length.
- FIFO: circular, read/write pointers of log2(DEPTH)+1 bits with a wrap bit; full when low bits are equal and wrap bits differ; empty when pointers are equal.
- Push when `in_valid && in_ready`. A push is never accepted while full, even if a pop occurs in the same cycle.
- Pop when an accepted grant occurs or an orphan flit is discarded. A pop request while empty is ignored.
- Simultaneous push and pop (not full, not empty): `count` is unchanged.
- FSM, two states:
  - IDLE: `req`=0; `gnt` ignored.
    - Head is a header: latch `length` from the head, go to ACTIVE. The header is not popped.
    - Head is a body/tail/unknown type: pop it and pulse `drop`. Remain IDLE. This repeats at one flit per cycle.
    - Empty: remain IDLE.
  - ACTIVE: `req`=1; `flit_id` = head type (000 if empty).
    - On a pop, the flit appears on `out_flit` with `out_valid`=1.
    - Popping a tail: return to IDLE in the next cycle.
    - Any other type, including a second header, is forwarded and the state remains ACTIVE.
- `length` holds its value until the next IDLE→ACTIVE transition.

## Timing
- Reset values:
  - Pointers = 0, `count` = 0, state = IDLE.
  - `req`, `drop`, `out_valid` = 0.
  - `flit_id` = 3'b000, `length` = 0, `out_flit` = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
- Write to head latency:
  - A flit pushed at edge N into an empty FIFO is at the head at N+1.
  - If it is a header, ACTIVE and `req`=1 follow at N+2.
  - The earliest grant is in the cycle after N+2.
- `out_flit`, `flit_id`, `out_valid` and `in_ready` are combinational from the head entry, state and `gnt`. `req` and `length` are registered.
- Throughput: one flit per cycle in and one out.
- Tail popped at edge M: `req`=0 from M. A following header already at the head raises `req` again at M+1. This gives a one-cycle gap so the arbiter re-arbitrates.
- A `rst` assertion mid-packet flushes all contents and returns to IDLE at the next edge. No flit is emitted.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 → `count`=0, `req`=0, `in_ready`=1, `flit_id`=000, `length`=0, and no write.
- Single packet: push header (length=12'd5), body, tail with `gnt`=1 throughout:
  - `req` rises 2 cycles after the header push.
  - `flit_id` sequence is 001, 010, 100, with `out_valid` 3 consecutive cycles.
  - `length`=5, and `req` falls after the tail pop.
- Orphans: push body, tail, then header → `drop` pulses 2 cycles, then `req`=1 with `flit_id`=001.
- Full/backpressure, DEPTH=8, `gnt`=0: push 10 flits →
  - `count`=8 and `in_ready`=0 after 8 pushes; the extra flits are not accepted.
  - Grant 1 cycle → `count`=7 and `in_ready`=1.
  - Full FIFO with pop and `in_valid` in the same cycle → `count` goes 8→7.
- Grant withheld: packet buffered, `gnt`=0 for 20 cycles → `req` stays 1, `flit_id`=001, contents are unchanged.
- Back-to-back packets plus wrap: stream 3 packets of 4 flits with `gnt`=1 →
  - Pointers wrap correctly.
  - Each packet's `length` is latched.
  - Exactly one `req`-low cycle between packets, and flits are output in order.
